mem_access_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the EX/MEM pipeline register.
- Resolves branches and jumps from the EX/MEM outputs.
- Runs each load or store through a req/ready data-memory bus handshake FSM and stalls the pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register feeding write-back.

---
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: branch resolve, req/ready data-memory FSM, MEM/WB register.
// Define MEM_BYTE_ACCESS_EN for byte/half loads and stores.
module mem_access_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWrite_in,
  input  logic            MemToReg_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic            Branch_in,
  input  logic            Jump_in,
  input  logic [XLEN-1:0] branch_target_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] write_data_in,
  input  logic [4:0]      rd_in,
  input  logic            zero_in,
  input  logic [2:0]      funct3_in,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            RegWrite_out,
  output logic            MemToReg_out,
  output logic [XLEN-1:0] read_data_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic              mem_op;
  logic [3:0]        wstrb_d;
  logic [XLEN-1:0]   wdata_d;
  logic [XLEN-1:0]   ld_fmt;
  logic [XLEN-1:0]   rdata_q;

  assign pc_src    = (Branch_in & zero_in) | Jump_in;
  assign pc_target = branch_target_in;
  assign mem_op    = MemRead_in | MemWrite_in;

`ifdef MEM_BYTE_ACCESS_EN
  logic [XLEN-1:0] ld_shift;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign ld_shift = dmem_rdata >> {alu_result_in[1:0], 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = alu_result_in[1] ? dmem_rdata[31:16]
                                     : dmem_rdata[15:0];

  // Store lane strobes and replicated store data
  always_comb begin
    wstrb_d = 4'b1111;
    wdata_d = write_data_in;
    case (funct3_in)
      3'b000: begin
        wstrb_d = 4'b0001 << alu_result_in[1:0];
        wdata_d = {4{write_data_in[7:0]}};
      end
      3'b001: begin
        wstrb_d = 4'b0011 << {alu_result_in[1], 1'b0};
        wdata_d = {2{write_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    ld_fmt = dmem_rdata;
    case (funct3_in)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ;
    endcase
  end
`else
  logic unused_funct3;

  assign unused_funct3 = ^funct3_in;
  assign wstrb_d       = 4'b1111;
  assign wdata_d       = write_data_in;
  assign ld_fmt        = dmem_rdata;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (mem_op) state_n = ACCESS;
      ACCESS:  if (dmem_ready) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stall while a memory op waits to issue or is outstanding
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:    mem_stall = mem_op;
      ACCESS:  mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Bus request registers and load-data latch
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= 4'b0000;
      rdata_q    <= '0;
    end else if (state == IDLE && mem_op) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MemWrite_in;
      dmem_addr  <= {alu_result_in[XLEN-1:2], 2'b00};
      dmem_wdata <= wdata_d;
      dmem_wstrb <= wstrb_d;
    end else if (state == ACCESS && dmem_ready) begin
      dmem_req <= 1'b0;
      rdata_q  <= dmem_we ? '0 : ld_fmt;
    end
  end

  // MEM/WB register; bubble while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite_out   <= 1'b0;
      MemToReg_out   <= 1'b0;
      read_data_out  <= '0;
      alu_result_out <= '0;
      rd_out         <= 5'd0;
    end else if (mem_stall) begin
      RegWrite_out <= 1'b0;
      MemToReg_out <= 1'b0;
    end else begin
      RegWrite_out   <= RegWrite_in;
      MemToReg_out   <= MemToReg_in;
      read_data_out  <= (state == DONE) ? rdata_q : '0;
      alu_result_out <= alu_result_in;
      rd_out         <= rd_in;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed test of mem_access_stage.
// Byte/half cases run only with MEM_BYTE_ACCESS_EN.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in;
  logic        Branch_in, Jump_in, zero_in;
  logic [31:0] branch_target_in, alu_result_in, write_data_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        pc_src, mem_stall, dmem_req, dmem_we, dmem_ready;
  logic [31:0] pc_target, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        RegWrite_out, MemToReg_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Branch_in(Branch_in), .Jump_in(Jump_in),
    .branch_target_in(branch_target_in),
    .alu_result_in(alu_result_in),
    .write_data_in(write_data_in), .rd_in(rd_in),
    .zero_in(zero_in), .funct3_in(funct3_in),
    .pc_src(pc_src), .pc_target(pc_target),
    .mem_stall(mem_stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nop();
    RegWrite_in = 0; MemToReg_in = 0; MemRead_in = 0;
    MemWrite_in = 0; Branch_in = 0; Jump_in = 0; zero_in = 0;
    branch_target_in = 0; alu_result_in = 0;
    write_data_in = 0; rd_in = 0; funct3_in = 3'b010;
  endtask

  initial begin
    reset = 1; dmem_ready = 0; dmem_rdata = 0;
    nop();
    step(); step();
    chk("rst_req", {31'd0, dmem_req}, 0);
    chk("rst_regwr", {31'd0, RegWrite_out}, 0);
    chk("rst_rdata", read_data_out, 0);
    chk("rst_addr", dmem_addr, 0);
    reset = 0;
    #1;
    chk("rst_stall", {31'd0, mem_stall}, 0);

    Jump_in = 1; branch_target_in = 32'h100;
    #1;
    chk("jmp_src", {31'd0, pc_src}, 1);
    chk("jmp_tgt", pc_target, 32'h100);
    Jump_in = 0; Branch_in = 1; zero_in = 0;
    #1;
    chk("br_nt", {31'd0, pc_src}, 0);
    zero_in = 1;
    #1;
    chk("br_tk", {31'd0, pc_src}, 1);
    nop();

    RegWrite_in = 1; alu_result_in = 32'h1234; rd_in = 5;
    #1;
    chk("alu_stall", {31'd0, mem_stall}, 0);
    step();
    chk("alu_regwr", {31'd0, RegWrite_out}, 1);
    chk("alu_res", alu_result_out, 32'h1234);
    chk("alu_rd", {27'd0, rd_out}, 5);
    chk("alu_stall2", {31'd0, mem_stall}, 0);

    RegWrite_in = 1; MemToReg_in = 1; MemRead_in = 1;
    alu_result_in = 32'h40; rd_in = 7;
    stall_cnt = 0;
    #1;
    if (mem_stall) stall_cnt++;
    step();
    chk("ld_req", {31'd0, dmem_req}, 1);
    chk("ld_we", {31'd0, dmem_we}, 0);
    chk("ld_addr", dmem_addr, 32'h40);
    chk("ld_bub_rw", {31'd0, RegWrite_out}, 0);
    chk("ld_bub_m2r", {31'd0, MemToReg_out}, 0);
    chk("ld_hold_alu", alu_result_out, 32'h1234);
    if (mem_stall) stall_cnt++;
    step();
    chk("ld_req_held", {31'd0, dmem_req}, 1);
    if (mem_stall) stall_cnt++;
    step();
    dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    if (mem_stall) stall_cnt++;
    step();
    dmem_ready = 0; dmem_rdata = 0;
    #1;
    chk("ld_req_drop", {31'd0, dmem_req}, 0);
    chk("ld_done_stall", {31'd0, mem_stall}, 0);
    chk("ld_stall_cnt", stall_cnt, 4);
    step();
    nop();
    chk("ld_rdata", read_data_out, 32'hDEADBEEF);
    chk("ld_m2r", {31'd0, MemToReg_out}, 1);
    chk("ld_regwr", {31'd0, RegWrite_out}, 1);
    chk("ld_rd", {27'd0, rd_out}, 7);
    chk("ld_alu", alu_result_out, 32'h40);

    MemRead_in = 1; MemWrite_in = 1; alu_result_in = 32'h44;
    write_data_in = 32'hA5A50F0F; rd_in = 3;
    dmem_ready = 1;
    #1;
    chk("st_stall", {31'd0, mem_stall}, 1);
    step();
    chk("st_req", {31'd0, dmem_req}, 1);
    chk("st_we", {31'd0, dmem_we}, 1);
    chk("st_addr", dmem_addr, 32'h44);
    chk("st_wdata", dmem_wdata, 32'hA5A50F0F);
    chk("st_wstrb", {28'd0, dmem_wstrb}, 32'hF);
    step();
    dmem_ready = 0;
    #1;
    chk("st_done_stall", {31'd0, mem_stall}, 0);
    step();
    nop();
    chk("st_regwr", {31'd0, RegWrite_out}, 0);
    chk("st_alu", alu_result_out, 32'h44);
    chk("st_rd", {27'd0, rd_out}, 3);

    RegWrite_in = 1; MemToReg_in = 1; MemRead_in = 1;
    alu_result_in = 32'h4B; rd_in = 8;
    step();
    chk("rs_req", {31'd0, dmem_req}, 1);
    chk("rs_addr_align", dmem_addr, 32'h48);
    reset = 1;
    nop();
    step();
    reset = 0;
    chk("rs_req0", {31'd0, dmem_req}, 0);
    chk("rs_stall0", {31'd0, mem_stall}, 0);
    dmem_ready = 1; dmem_rdata = 32'h11111111;
    step();
    dmem_ready = 0; dmem_rdata = 0;
    chk("rs_late_req", {31'd0, dmem_req}, 0);
    chk("rs_late_rdata", read_data_out, 0);
    RegWrite_in = 1; rd_in = 0; alu_result_in = 32'h9;
    #1;
    chk("rs_idle_stall", {31'd0, mem_stall}, 0);
    step();
    chk("x0_regwr", {31'd0, RegWrite_out}, 1);
    chk("x0_rd", {27'd0, rd_out}, 0);
    chk("x0_alu", alu_result_out, 32'h9);
    nop();

`ifdef MEM_BYTE_ACCESS_EN
    RegWrite_in = 1; MemToReg_in = 1; MemRead_in = 1;
    alu_result_in = 32'h43; funct3_in = 3'b000; rd_in = 4;
    step();
    dmem_ready = 1; dmem_rdata = 32'h80FFFFFF;
    step();
    dmem_ready = 0;
    step();
    chk("lb", read_data_out, 32'hFFFFFF80);
    funct3_in = 3'b100;
    step();
    dmem_ready = 1;
    step();
    dmem_ready = 0;
    step();
    chk("lbu", read_data_out, 32'h00000080);
    nop();
    MemWrite_in = 1; alu_result_in = 32'h42;
    write_data_in = 32'h00001234; funct3_in = 3'b001;
    step();
    chk("sh_wstrb", {28'd0, dmem_wstrb}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h12341234);
    chk("sh_addr", dmem_addr, 32'h40);
    dmem_ready = 1;
    step();
    dmem_ready = 0;
    step();
    nop();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
